// File: rtl/pipeline_hazard_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Stall/flush sequencer for a 5-stage RISC-V pipeline. It
//               handles load-use hazards, taken branches/jumps and a
//               multi-cycle data-memory handshake with a timeout. It also
//               keeps saturating stall/flush event counters.
// Ports       : clk                       pipeline clock, rising edge
//               rst                       asynchronous reset, active low
//               load_e, rd_e              load in execute and its destination
//               rs1_d, rs2_d              decode-stage source registers
//               pcsrc_e                   branch taken / jump in execute
//               mem_req_m, mem_ready      memory-stage access handshake
//               stall_f/d/e/m             per-stage hold enables
//               flush_d/e/w               per-stage bubble/NOP injection
//               mem_error                 sticky memory-timeout flag
//               stall_cnt, flush_cnt      saturating event counters
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_e,
   input  logic [4:0]       rd_e,
   input  logic [4:0]       rs1_d,
   input  logic [4:0]       rs2_d,
   input  logic             pcsrc_e,
   input  logic             mem_req_m,
   input  logic             mem_ready,
   output logic             stall_f,
   output logic             stall_d,
   output logic             stall_e,
   output logic             stall_m,
   output logic             flush_d,
   output logic             flush_e,
   output logic             flush_w,
   output logic             mem_error,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam logic [1:0] S_RUN      = 2'd0;
   localparam logic [1:0] S_MEM_WAIT = 2'd1;
   localparam logic [1:0] S_ERR      = 2'd2;

   // Wait-counter value on the last tolerated stall cycle of an access.
   localparam logic [7:0] WAIT_LAST  = 8'(MEM_TIMEOUT - 1);

   logic [1:0] state;
   logic [1:0] state_nxt;
   logic [7:0] wait_cnt;
   logic [7:0] wait_cnt_nxt;
   logic       mem_stall;
   logic       lu;

   assign mem_stall = mem_req_m & ~mem_ready;
   // x0 is hardwired to zero, so a load targeting it never creates a hazard.
   assign lu = load_e & (rd_e != 5'd0) & ((rd_e == rs1_d) | (rd_e == rs2_d));

   assign mem_error = (state == S_ERR);

   // Output priority: freeze (error or memory wait) > branch flush > load-use.
   // Everything is forced low while reset is asserted.
   always_comb begin
      stall_f = 1'b0;
      stall_d = 1'b0;
      stall_e = 1'b0;
      stall_m = 1'b0;
      flush_d = 1'b0;
      flush_e = 1'b0;
      flush_w = 1'b0;
      if (rst) begin
         if ((state == S_ERR) || mem_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
         end else if (pcsrc_e) begin
            // Decode instruction is on the wrong path, so any lu is moot.
            flush_d = 1'b1;
            flush_e = 1'b1;
         end else if (lu) begin
            // One bubble is enough: the load reaches memory next cycle.
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      case (state)
         S_RUN: begin
            if (mem_stall) begin
               state_nxt    = S_MEM_WAIT;
               wait_cnt_nxt = 8'd1;
            end
         end
         S_MEM_WAIT: begin
            if (!mem_stall) begin
               state_nxt    = S_RUN;
               wait_cnt_nxt = 8'd0;
            end else if (wait_cnt == WAIT_LAST) begin
               state_nxt    = S_ERR;
            end else begin
               wait_cnt_nxt = wait_cnt + 8'd1;
            end
         end
         S_ERR: begin
            state_nxt = S_ERR;
         end
         default: begin
            state_nxt    = S_RUN;
            wait_cnt_nxt = 8'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_RUN;
         wait_cnt <= 8'd0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
      end
   end

   // Performance counters hold at all-ones instead of wrapping.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall_f && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
         end
         if (flush_d && (flush_cnt != {CNT_W{1'b1}})) begin
            flush_cnt <= flush_cnt + 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_ctrl
// Description : Self-checking bench for pipeline_hazard_ctrl. A behavioural
//               model predicts outputs every cycle; directed vectors carry
//               hand-computed literal expectations as well.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

   localparam int T    = 4;
   localparam int CW   = 4;
   localparam int CMAX = 15;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          load_e = 1'b0;
   logic [4:0]    rd_e = '0;
   logic [4:0]    rs1_d = '0;
   logic [4:0]    rs2_d = '0;
   logic          pcsrc_e = 1'b0;
   logic          mem_req_m = 1'b0;
   logic          mem_ready = 1'b0;
   logic          stall_f, stall_d, stall_e, stall_m;
   logic          flush_d, flush_e, flush_w;
   logic          mem_error;
   logic [CW-1:0] stall_cnt;
   logic [CW-1:0] flush_cnt;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(
      .MEM_TIMEOUT (T),
      .CNT_W       (CW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .load_e    (load_e),
      .rd_e      (rd_e),
      .rs1_d     (rs1_d),
      .rs2_d     (rs2_d),
      .pcsrc_e   (pcsrc_e),
      .mem_req_m (mem_req_m),
      .mem_ready (mem_ready),
      .stall_f   (stall_f),
      .stall_d   (stall_d),
      .stall_e   (stall_e),
      .stall_m   (stall_m),
      .flush_d   (flush_d),
      .flush_e   (flush_e),
      .flush_w   (flush_w),
      .mem_error (mem_error),
      .stall_cnt (stall_cnt),
      .flush_cnt (flush_cnt)
   );

   // {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w}
   logic [6:0] act_o;
   assign act_o = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w};

   // ---------------- behavioural model ----------------
   // Tracks only "is the pipe dead" and "how many consecutive cycles has the
   // current access been stalling"; counters are plain saturating integers.
   bit m_err   = 1'b0;
   int m_waits = 0;
   int m_scnt  = 0;
   int m_fcnt  = 0;

   function automatic logic [6:0] exp_outs();
      logic hazard;
      if (!rst) return 7'b0;
      hazard = load_e && (rd_e != 5'd0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
      if (m_err || (mem_req_m && !mem_ready)) return 7'b1111001;
      if (pcsrc_e) return 7'b0000110;
      if (hazard)  return 7'b1100010;
      return 7'b0;
   endfunction

   logic [6:0] exp_now;
   always_comb exp_now = exp_outs();

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_err   <= 1'b0;
         m_waits <= 0;
         m_scnt  <= 0;
         m_fcnt  <= 0;
      end else begin
         if (exp_now[6] && (m_scnt < CMAX)) m_scnt <= m_scnt + 1;
         if (exp_now[2] && (m_fcnt < CMAX)) m_fcnt <= m_fcnt + 1;
         if (!m_err) begin
            if (mem_req_m && !mem_ready) begin
               m_waits <= m_waits + 1;
               if (m_waits + 1 == T) m_err <= 1'b1;
            end else begin
               m_waits <= 0;
            end
         end
      end
   end

   // Per-cycle comparison on the falling edge.
   always @(negedge clk) begin
      vectors++;
      if ((act_o !== exp_now) || (mem_error !== m_err) ||
          (stall_cnt !== CW'(m_scnt)) || (flush_cnt !== CW'(m_fcnt))) begin
         miscompares++;
         $display("FAIL cycle_model t=%0t: got outs=%b err=%b sc=%0d fc=%0d, expected outs=%b err=%b sc=%0d fc=%0d",
                  $time, act_o, mem_error, stall_cnt, flush_cnt, exp_now, m_err, m_scnt, m_fcnt);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input logic ld, input logic [4:0] rd, input logic [4:0] r1,
                        input logic [4:0] r2, input logic pc, input logic rq, input logic rdy);
      load_e    = ld;
      rd_e      = rd;
      rs1_d     = r1;
      rs2_d     = r2;
      pcsrc_e   = pc;
      mem_req_m = rq;
      mem_ready = rdy;
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      // Reset with every event input active: outputs must stay low.
      drive(1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0);
      tick();
      #1;
      chk("reset_outs", act_o, 0);
      chk("reset_err", mem_error, 0);
      chk("reset_scnt", stall_cnt, 0);
      chk("reset_fcnt", flush_cnt, 0);
      tick();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      tick();

      // Load-use on rs2.
      drive(1'b1, 5'd5, 5'd1, 5'd5, 1'b0, 1'b0, 1'b0);
      #1 chk("lu_outs", act_o, 7'b1100010);
      tick();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      #1 chk("lu_release", act_o, 0);
      chk("lu_scnt", stall_cnt, 1);
      tick();

      // x0 destination never stalls.
      drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      #1 chk("x0_no_stall", act_o, 0);
      tick();

      // Branch wins over a simultaneous load-use.
      drive(1'b1, 5'd3, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0);
      #1 chk("br_over_lu", act_o, 7'b0000110);
      tick();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      #1 chk("br_fcnt", flush_cnt, 1);
      chk("br_scnt", stall_cnt, 1);
      tick();

      // Memory wait of 3 cycles; branch+lu in the middle are ignored.
      for (int i = 0; i < 3; i++) begin
         if (i == 1) drive(1'b1, 5'd3, 5'd3, 5'd0, 1'b1, 1'b1, 1'b0);
         else        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
         #1 chk("mem_wait_outs", act_o, 7'b1111001);
         tick();
      end
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
      #1 chk("mem_done_outs", act_o, 0);
      tick();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      #1 chk("mem_scnt", stall_cnt, 4);
      chk("mem_fcnt", flush_cnt, 1);
      chk("mem_err_clear", mem_error, 0);
      tick();

      // Stall counter saturation.
      repeat (20) begin
         drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
         tick();
      end
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      #1 chk("sat_scnt", stall_cnt, 15);
      tick();

      // Synchronous-looking reset pulse between tests.
      rst = 1'b0;
      #1 chk("pulse_scnt", stall_cnt, 0);
      tick();
      rst = 1'b1;
      tick();

      // Timeout: T stall cycles, then ERR.
      for (int i = 0; i < T; i++) begin
         drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
         #1 chk("to_wait_outs", act_o, 7'b1111001);
         chk("to_wait_err", mem_error, 0);
         tick();
      end
      #1 chk("to_err_set", mem_error, 1);
      chk("to_err_scnt", stall_cnt, 4);
      tick();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
      #1 chk("err_ready_outs", act_o, 7'b1111001);
      chk("err_sticky", mem_error, 1);
      tick();
      drive(1'b1, 5'd3, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0);
      #1 chk("err_branch_outs", act_o, 7'b1111001);
      chk("err_scnt", stall_cnt, 6);
      tick();
      rst = 1'b0;
      #1 chk("err_rst_outs", act_o, 0);
      chk("err_rst_err", mem_error, 0);
      chk("err_rst_scnt", stall_cnt, 0);
      tick();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      tick();

      // Asynchronous reset in the middle of a clock period during MEM_WAIT.
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
      tick();
      tick();
      #1 rst = 1'b0;
      #1 chk("async_outs", act_o, 0);
      chk("async_scnt", stall_cnt, 0);
      chk("async_err", mem_error, 0);
      tick();
      rst = 1'b1;
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
      #1 chk("async_ready_first", act_o, 0);
      tick();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      repeat (2) tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RISC-V pipeline (fetch, decode, execute, memory, writeback).
- Sits beside the existing forwarding unit and generates per-stage stall/flush enables for:
  - load-use hazards
  - taken branches/jumps
  - a multi-cycle data-memory handshake with timeout
- Keeps saturating stall/flush event counters for performance debug.

Parameters:
- MEM_TIMEOUT, 16, max consecutive wait cycles on a memory access before error; legal range 2..255.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- load_e  input  1  the instruction in execute is a load (result select = memory).
- rd_e  input  5  destination register of the execute-stage instruction.
- rs1_d  input  5  source register 1 of the decode-stage instruction.
- rs2_d  input  5  source register 2 of the decode-stage instruction.
- pcsrc_e  input  1  branch taken or jump resolved in execute.
- mem_req_m  input  1  load or store present in the memory stage.
- mem_ready  input  1  data memory completes the access this cycle.
- stall_f  output  1  hold the PC register.
- stall_d  output  1  hold the fetch/decode register.
- stall_e  output  1  hold the decode/execute register.
- stall_m  output  1  hold the execute/memory register.
- flush_d  output  1  clear the fetch/decode register (inject NOP).
- flush_e  output  1  clear the decode/execute register (inject bubble).
- flush_w  output  1  clear the memory/writeback register (bubble into writeback).
- mem_error  output  1  sticky memory-timeout error flag.
- stall_cnt  output  CNT_W  cycles with stall_f asserted, saturating.
- flush_cnt  output  CNT_W  accepted branch flushes, saturating.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to RUN and the wait counter clears.
  - mem_error=0, stall_cnt=0, flush_cnt=0.
  - All stall and flush outputs are 0 while in reset, regardless of other inputs.
- FSM states:
  - RUN: normal operation.
  - MEM_WAIT: a memory access is outstanding.
  - ERR: terminal state, left only by reset.
- Derived terms (combinational):
  - mem_stall = mem_req_m & ~mem_ready.
  - lu = load_e & (rd_e != 0) & ((rd_e == rs1_d) | (rd_e == rs2_d)).
- Output priority in RUN/MEM_WAIT (combinational, same cycle, no added latency):
  1. mem_stall=1: stall_f=stall_d=stall_e=stall_m=1, flush_w=1, and flush_d=flush_e=0. pcsrc_e and lu are ignored because the stages are frozen and are re-evaluated after release.
  2. Otherwise pcsrc_e=1: flush_d=1, flush_e=1, all stalls 0. A branch overrides a simultaneous lu, since the decode instruction is on the wrong path.
  3. Otherwise lu=1: stall_f=stall_d=1, flush_e=1, and stall_e=stall_m=0. The stall lasts exactly 1 cycle, because the load advances to memory the next cycle.
  4. Otherwise all stall and flush outputs are 0.
- ERR state outputs:
  - All four stalls are 1 and flush_w=1, freezing the pipeline.
  - flush_d=flush_e=0.
  - mem_error=1.
- Transitions (registered):
  - RUN→MEM_WAIT when mem_stall; the wait counter loads 1.
  - MEM_WAIT→RUN when mem_ready=1 or mem_req_m=0; the counter clears.
  - MEM_WAIT→ERR when mem_stall holds and the counter equals MEM_TIMEOUT-1; otherwise the counter increments.
  - ERR stays in ERR until reset.
- Wait timing:
  - An access with mem_ready on the first cycle causes no stall.
  - An access with ready arriving on wait cycle k (k < MEM_TIMEOUT) stalls exactly k cycles.
  - An access still not ready after MEM_TIMEOUT cycles enters ERR on the next edge.
- Counters:
  - stall_cnt increments on each edge where stall_f=1, including ERR cycles.
  - flush_cnt increments on each edge where flush_d=1 due to pcsrc_e.
  - Both saturate at 2^CNT_W-1 and never wrap.
- x0 is never a hazard source: rd_e=0 gives lu=0.

Test Plan:
- Load-use: load_e=1, rd_e=5, rs2_d=5, no other events → for 1 cycle stall_f=stall_d=1, flush_e=1, stall_e=0; next cycle (load_e=0) all 0; stall_cnt=1.
- x0 and branch priority:
  - rd_e=0, rs1_d=0, load_e=1 → no stall.
  - Then load_e=1, rd_e=3, rs1_d=3 with pcsrc_e=1 → flush_d=flush_e=1, stall_f=0, flush_cnt=1.
- Memory wait: mem_req_m=1 with mem_ready low for 3 cycles then high → stalls high for exactly 3 cycles with flush_w=1, FSM returns to RUN, stall_cnt=3, mem_error=0.
- Timeout: MEM_TIMEOUT=4, mem_req_m=1, mem_ready=0 held → ERR entered after 4 stall cycles, mem_error=1 sticky, stalls remain 1 when mem_ready later rises; rst pulse low clears everything.
- Saturation and async reset:
  - CNT_W=4, hold a load-use stall for 20 cycles → stall_cnt stops at 15.
  - Assert rst low mid-clock during MEM_WAIT → outputs and counters are 0 immediately, without waiting for a clock edge.
